// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dram_arbiter_pkg;

  localparam int unsigned HWAIT_W = 4;

  // Owner of the read data returning from the RAM in the following cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CORE = 2'd1,
    RD_HOST = 2'd2
  } rd_owner_t;

  // One-hot grant: at most one bit set in any cycle.
  typedef struct packed {
    logic w;
    logic r;
    logic h;
  } grant_t;

endpackage

// File: rtl/dram_grant.sv
// Combinational grant encoder: fixed W > R > H priority, host promoted when
// its starvation bound is reached, host lock excludes both core requesters.
module dram_grant
  import dram_arbiter_pkg::*;
(
  input  logic   w_req,
  input  logic   r_req,
  input  logic   h_req,
  input  logic   h_lock,
  input  logic   host_due,
  output grant_t gnt
);

  // Select at most one winner from the current requests.
  always_comb begin
    gnt = '0;
    if (h_lock) begin
      gnt.h = h_req;
    end else if (host_due && h_req) begin
      gnt.h = 1'b1;
    end else if (w_req) begin
      gnt.w = 1'b1;
    end else if (r_req) begin
      gnt.r = 1'b1;
    end else if (h_req) begin
      gnt.h = 1'b1;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates one single-port data RAM between the write-back stage, the
// data-fetch stage and a host/debug port, one access per cycle.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 12,
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned HOST_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_req,
  input  logic [A_WIDTH-1:0] w_a,
  input  logic [D_WIDTH-1:0] w_d,
  output logic               w_ack,
  input  logic               r_req,
  input  logic [A_WIDTH-1:0] r_a,
  output logic               r_ack,
  output logic               r_drdy,
  output logic [D_WIDTH-1:0] r_q,
  input  logic               h_req,
  input  logic               h_we,
  input  logic [A_WIDTH-1:0] h_a,
  input  logic [D_WIDTH-1:0] h_d,
  input  logic               h_lock,
  output logic               h_ack,
  output logic               h_drdy,
  output logic [D_WIDTH-1:0] h_q,
  output logic               mce,
  output logic               mwe,
  output logic [A_WIDTH-1:0] ma,
  output logic [D_WIDTH-1:0] md,
  input  logic [D_WIDTH-1:0] mq
);

  localparam logic [HWAIT_W-1:0] HOST_WAIT_L = HWAIT_W'(HOST_WAIT);

  grant_t               gnt;
  logic [HWAIT_W-1:0]   hwait;
  rd_owner_t            rd_owner;
  logic [D_WIDTH-1:0]   r_q_hold;
  logic [D_WIDTH-1:0]   h_q_hold;
  logic                 core_ret;
  logic                 host_ret;

  // Requests are masked while reset is high so no grant, ack or RAM access
  // can leak out during the reset cycle itself.
  dram_grant u_grant (
    .w_req    (w_req & ~reset),
    .r_req    (r_req & ~reset),
    .h_req    (h_req & ~reset),
    .h_lock   (h_lock),
    .host_due (hwait == HOST_WAIT_L),
    .gnt      (gnt)
  );

  assign w_ack = gnt.w;
  assign r_ack = gnt.r;
  assign h_ack = gnt.h;

  // Route the winner's operands onto the RAM port.
  always_comb begin
    mce = 1'b0;
    mwe = 1'b0;
    ma  = '0;
    md  = '0;
    if (gnt.w) begin
      mce = 1'b1;
      mwe = 1'b1;
      ma  = w_a;
      md  = w_d;
    end else if (gnt.r) begin
      mce = 1'b1;
      ma  = r_a;
    end else if (gnt.h) begin
      mce = 1'b1;
      mwe = h_we;
      ma  = h_a;
      md  = h_d;
    end
  end

  // Read data appears on mq one cycle after the grant; the owner register
  // steers it to the right port, and the hold register keeps the last value
  // so q is registered state outside the return cycle.
  assign core_ret = (rd_owner == RD_CORE) && !reset;
  assign host_ret = (rd_owner == RD_HOST) && !reset;
  assign r_drdy   = core_ret;
  assign h_drdy   = host_ret;

  // Return-path mux: live RAM data in the return cycle, held value otherwise.
  always_comb begin
    r_q = r_q_hold;
    h_q = h_q_hold;
    if (reset) begin
      r_q = '0;
      h_q = '0;
    end else begin
      if (core_ret) r_q = mq;
      if (host_ret) h_q = mq;
    end
  end

  // Starvation counter, read-owner tracking and read-data hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hwait    <= '0;
      rd_owner <= RD_NONE;
      r_q_hold <= '0;
      h_q_hold <= '0;
    end else begin
      if (!h_req || gnt.h) begin
        hwait <= '0;
      end else if (hwait != HOST_WAIT_L) begin
        hwait <= hwait + 1'b1;
      end

      if (gnt.r) begin
        rd_owner <= RD_CORE;
      end else if (gnt.h && !h_we) begin
        rd_owner <= RD_HOST;
      end else begin
        rd_owner <= RD_NONE;
      end

      if (rd_owner == RD_CORE) r_q_hold <= mq;
      if (rd_owner == RD_HOST) h_q_hold <= mq;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural RAM and a read-data
// scoreboard checked by an independent monitor.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_req, r_req, h_req, h_we, h_lock;
  logic [11:0] w_a, r_a, h_a;
  logic [7:0]  w_d, h_d;
  logic        w_ack, r_ack, r_drdy, h_ack, h_drdy;
  logic [7:0]  r_q, h_q;
  logic        mce, mwe;
  logic [11:0] ma;
  logic [7:0]  md;
  logic [7:0]  mq = 8'h00;

  logic [7:0]  mem [0:4095];

  logic [7:0]  rq[$];
  logic [7:0]  hq[$];

  int checks = 0;
  int errors = 0;

  dram_arbiter #(.A_WIDTH(12), .D_WIDTH(8), .HOST_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .w_req(w_req), .w_a(w_a), .w_d(w_d), .w_ack(w_ack),
    .r_req(r_req), .r_a(r_a), .r_ack(r_ack), .r_drdy(r_drdy), .r_q(r_q),
    .h_req(h_req), .h_we(h_we), .h_a(h_a), .h_d(h_d), .h_lock(h_lock),
    .h_ack(h_ack), .h_drdy(h_drdy), .h_q(h_q),
    .mce(mce), .mwe(mwe), .ma(ma), .md(md), .mq(mq)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read data valid the cycle after enable.
  always @(posedge clk) begin
    if (mce) begin
      if (mwe) mem[ma] <= md;
      else     mq      <= mem[ma];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every returned read against the scoreboard.
  always @(negedge clk) begin
    if (r_drdy === 1'b1) begin
      if (rq.size() == 0) chk("r_drdy_spurious", 64'(r_drdy), 64'd0);
      else                chk("r_q", 64'(r_q), 64'(rq.pop_front()));
    end
    if (h_drdy === 1'b1) begin
      if (hq.size() == 0) chk("h_drdy_spurious", 64'(h_drdy), 64'd0);
      else                chk("h_q", 64'(h_q), 64'(hq.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clr();
    w_req = 0; r_req = 0; h_req = 0; h_we = 0; h_lock = 0;
    w_a = '0; r_a = '0; h_a = '0; w_d = '0; h_d = '0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({w_ack, r_ack, h_ack, r_drdy, h_drdy, r_q, h_q, mce, mwe, ma, md});
  endfunction

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    w_req = 1; w_a = a; w_d = d;
    settle();
    chk("preload_w_ack", 64'(w_ack), 64'd1);
    tick();
    w_req = 0;
  endtask

  initial begin
    clr();
    reset = 1;
    settle();
    chk("reset_outputs", all_outs(), 64'd0);
    tick(); tick();
    reset = 0;
    settle();
    chk("idle_outputs", all_outs(), 64'd0);
    tick();

    // Core write, then read-after-write of the same address.
    w_req = 1; w_a = 12'h010; w_d = 8'hA5;
    settle();
    chk("w_ack", 64'(w_ack), 64'd1);
    chk("w_bus", 64'({mce, mwe, ma, md}), 64'({1'b1, 1'b1, 12'h010, 8'hA5}));
    tick();
    w_req = 0; r_req = 1; r_a = 12'h010;
    rq.push_back(8'hA5);
    settle();
    chk("r_ack", 64'(r_ack), 64'd1);
    chk("r_bus", 64'({mce, mwe, ma, md}), 64'({1'b1, 1'b0, 12'h010, 8'h00}));
    tick();
    r_req = 0;
    settle();
    chk("r_drdy_pulse", 64'({r_drdy, r_q}), 64'({1'b1, 8'hA5}));
    tick();
    settle();
    chk("r_q_hold", 64'({r_drdy, r_q}), 64'({1'b0, 8'hA5}));
    tick();

    wr(12'h030, 8'h5A);
    wr(12'h001, 8'h11);
    wr(12'h002, 8'h22);
    wr(12'h003, 8'h33);

    // Starvation: W wins 4 times, host promoted on the 5th cycle.
    w_req = 1; w_a = 12'h020; w_d = 8'h01;
    r_req = 1; r_a = 12'h030;
    h_req = 1; h_we = 0; h_a = 12'h010;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("starve_w_ack", 64'(w_ack), 64'd1);
      chk("starve_h_refused", 64'(h_ack), 64'd0);
      tick();
    end
    hq.push_back(8'hA5);
    settle();
    chk("starve_grant", 64'({w_ack, r_ack, h_ack}), 64'b001);
    tick();
    // hwait must have cleared: a new host request waits a full 4 cycles again.
    h_a = 12'h020;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rewait_h_refused", 64'({w_ack, h_ack}), 64'b10);
      tick();
    end
    hq.push_back(8'h01);
    settle();
    chk("rewait_grant", 64'({w_ack, r_ack, h_ack}), 64'b001);
    tick();
    h_req = 0; w_req = 0;
    rq.push_back(8'h5A);
    settle();
    chk("r_after_w", 64'(r_ack), 64'd1);
    tick();

    // Host lock: host write granted, core read refused.
    h_lock = 1; h_req = 1; h_we = 1; h_a = 12'hFFF; h_d = 8'h3C;
    r_req = 1; r_a = 12'hFFF;
    settle();
    chk("lock_grant", 64'({w_ack, r_ack, h_ack}), 64'b001);
    chk("lock_bus", 64'({mce, mwe, ma, md}), 64'({1'b1, 1'b1, 12'hFFF, 8'h3C}));
    tick();
    h_req = 0; h_we = 0; h_lock = 0;
    rq.push_back(8'h3C);
    settle();
    chk("unlock_r_ack", 64'(r_ack), 64'd1);
    tick();
    // Lock raised with a core read outstanding: return still fires.
    r_req = 0; h_lock = 1; w_req = 1; w_a = 12'h040; w_d = 8'h77;
    settle();
    chk("lock_blocks_w", 64'({w_ack, mce}), 64'b00);
    chk("lock_drdy", 64'(r_drdy), 64'd1);
    tick();
    w_req = 0; h_lock = 0;

    // Back-to-back host reads.
    h_req = 1; h_we = 0;
    for (int i = 1; i <= 3; i++) begin
      h_a = 12'(i);
      hq.push_back(8'(8'h11 * i));
      settle();
      chk("hrd_ack", 64'(h_ack), 64'd1);
      if (i > 1) chk("hrd_drdy", 64'({h_drdy, r_drdy}), 64'b10);
      tick();
    end
    h_req = 0;
    settle();
    chk("hrd_drdy_last", 64'({h_drdy, r_drdy}), 64'b10);
    tick();
    settle();
    chk("hrd_hold", 64'({h_drdy, h_q}), 64'({1'b0, 8'h33}));
    tick();

    // Reset the cycle after a read ack: the return is dropped.
    r_req = 1; r_a = 12'h010;
    settle();
    chk("rst_r_ack", 64'(r_ack), 64'd1);
    tick();
    r_req = 0; reset = 1;
    settle();
    chk("rst_drop_drdy", 64'(r_drdy), 64'd0);
    chk("rst_outputs", all_outs(), 64'd0);
    tick();
    reset = 0;
    settle();
    chk("post_rst_outputs", all_outs(), 64'd0);
    tick();

    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("hq_drained", 64'(hq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares one synchronous single-port data RAM between three requesters: the write-back stage (write), the data-fetch stage (read), and a host/debug port (read or write). It sits between those two core pipeline stages and the RAM macro. It replaces their direct connections to the RAM. It serialises accesses at one per cycle under fixed priority, with a starvation bound for the host and a host lock that freezes the core.

## Interface
- A_WIDTH, 12, data address width
- D_WIDTH, 8, data word width
- HOST_WAIT, 4, max consecutive cycles a pending host request may be refused; range 1..15
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- w_req / w_a / w_d  in  1 / A_WIDTH / D_WIDTH  write-back request, address, data
- w_ack  out  1  write accepted this cycle
- r_req / r_a  in  1 / A_WIDTH  data-fetch read request, address
- r_ack  out  1  read accepted this cycle
- r_drdy  out  1  r_q valid (one cycle after r_ack)
- r_q  out  D_WIDTH  read data
- h_req / h_we / h_a / h_d  in  1 / 1 / A_WIDTH / D_WIDTH  host request, write enable, address, data
- h_lock  in  1  host holds the RAM exclusively; core requests refused
- h_ack  out  1  host request accepted this cycle
- h_drdy  out  1  h_q valid (one cycle after a host read ack)
- h_q  out  D_WIDTH  host read data
- mce / mwe / ma / md  out  1 / 1 / A_WIDTH / D_WIDTH  RAM enable, write enable, address, write data
- mq  in  D_WIDTH  RAM read data; valid the cycle after a read enable

## Operation
- Exactly one grant per cycle at most. The grant is combinational from the current requests and the registered state. The ack for that grant is asserted in the same cycle.
- A requester holds its req and operands stable until it samples ack high. Req may drop only after ack.
- Default priority is W > R > H.
- Starvation counter `hwait` (4 bits) increments each cycle that h_req=1 and h_ack=0. It clears on h_ack and on cycles with h_req=0.
- When hwait == HOST_WAIT, the host wins over both W and R.
- h_lock=1 blocks W and R (w_ack=r_ack=0) regardless of priority; the host is granted whenever h_req=1.
- Grant drives the RAM: mce=1, mwe=granted op is a write, ma and md taken from the winner. With no grant, mce=0, mwe=0, and ma/md are don't-care (driven 0).
- Read return uses a registered 2-bit `rd_owner` (NONE/CORE/HOST) captured on a read grant.
  - Next cycle: the matching drdy pulses for 1 cycle and its q output is driven from mq.
  - q outputs are registered and hold their last value otherwise.
- Read and write to the same address in consecutive cycles: the RAM is read-after-write-ordered by cycle, so a read granted after a write returns the new data. There is no forwarding.

## Timing
- Reset: all acks 0, r_drdy=h_drdy=0, r_q=h_q=0, mce=mwe=0, ma=md=0, hwait=0, rd_owner=NONE.
- Accept latency is 0 cycles (same-cycle ack). Read data latency is 1 cycle after ack.
- Back-to-back reads: a new read may be acked in the same cycle the previous drdy pulses; throughput is 1 access/cycle.
- Reset asserted mid-read: the pending drdy is lost (rd_owner→NONE). Requesters must reissue.
- Lock asserted while a core read is outstanding: its drdy still fires next cycle. Lock affects grants only.
- hwait saturates at HOST_WAIT and never wraps.

## Structure
- Shared constants file gets the owner encodings RD_NONE=0, RD_CORE=1, RD_HOST=2.
- One natural sub-module, `dram_grant`: a combinational priority/starvation/lock encoder that outputs a one-hot grant (W, R, H). Registers and the RAM mux stay in dram_arbiter.

## Test plan
- After reset with all req=0: every output is 0. Then w_req with a=0x010, d=0xA5 → w_ack and mce=mwe=1, ma=0x010, md=0xA5 the same cycle.
- r_req with a=0x010 in the cycle after that write → r_ack, then next cycle r_drdy=1 and r_q=0xA5.
- w_req, r_req and h_req all held high → W acked each cycle. After 4 host refusals, h_ack fires on the 5th cycle, then hwait=0.
- h_lock=1 with h_req (write 0x3C at 0xFFF) and r_req → only h_ack. After h_lock drops, r_ack is given the next cycle.
- Continuous host reads at 0x001, 0x002, 0x003 → h_drdy high 3 consecutive cycles with the matching data, and no core drdy.
- Reset asserted the cycle after r_ack → r_drdy stays 0 and all outputs return to their reset values.
